// File: rtl/pc_seq.sv
// pc_seq -- program counter sequencer with return stack and one-level interrupt.
//
// Computes the next PC from a 4-bit operation code: increment, reset vector,
// conditional relative branches on zero/carry, absolute jump, call/return
// through a return-address stack, and return-from-interrupt.  A level
// interrupt request, taken only while running and enabled, saves the PC that
// would otherwise have been loaded and vectors to INT_VEC.
//
// Optional feature: define PC_SEQ_STACK_CHECK_EN to make the return stack
// refuse pushes when full and pops when empty, recording sticky overflow /
// underflow flags.  Without it the stack is circular and both flags read 0.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   en_i         advance the sequencer this cycle; when low all state holds
//   pcoper_i     PC operation code
//   carry_i      ALU carry flag for conditional branches
//   zero_i       ALU zero flag for conditional branches
//   offset_i     two's-complement branch offset (OFF_W bits)
//   addr_i       absolute jump / call target
//   int_req_i    interrupt request (level)
//   pc_o         registered program counter
//   int_ack_o    one-cycle pulse when an interrupt is taken
//   int_act_o    high while servicing an interrupt
//   depth_o      return-stack occupancy
//   stack_ovf_o  sticky overflow flag
//   stack_unf_o  sticky underflow flag
module pc_seq #(
    parameter int ADDR_W      = 12,
    parameter int OFF_W       = 8,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_VEC   = 0,
    parameter int INT_VEC     = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               en_i,
    input  logic [3:0]                         pcoper_i,
    input  logic                               carry_i,
    input  logic                               zero_i,
    input  logic [OFF_W-1:0]                   offset_i,
    input  logic [ADDR_W-1:0]                  addr_i,
    input  logic                               int_req_i,
    output logic [ADDR_W-1:0]                  pc_o,
    output logic                               int_ack_o,
    output logic                               int_act_o,
    output logic [$clog2(STACK_DEPTH):0]       depth_o,
    output logic                               stack_ovf_o,
    output logic                               stack_unf_o
);

    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int DEP_W = SP_W + 1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_INT = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       pc_q;
    logic [ADDR_W-1:0]       int_pc_q;
    logic [SP_W-1:0]         sp_q;
    logic [DEP_W-1:0]        depth_q;
    logic                    ack_q;
    logic [ADDR_W-1:0]       stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]       pc_inc;
    logic [ADDR_W-1:0]       pc_br;
    logic signed [ADDR_W-1:0] off_sext;
    logic [ADDR_W-1:0]       stack_top;

    logic [ADDR_W-1:0]       pc_d;
    logic                    push;
    logic                    pop;
    logic                    push_ok;
    logic                    pop_ok;
    logic                    reti;
    logic                    ovf_set;
    logic                    unf_set;
    logic [SP_W-1:0]         sp_d;
    logic [DEP_W-1:0]        depth_d;

    // Occupancy saturates at both ends; the circular stack keeps moving its
    // pointer past these limits while the count stays pinned.
    function automatic logic [DEP_W-1:0] depth_sat_inc(input logic [DEP_W-1:0] d);
        return (d == DEP_W'(STACK_DEPTH)) ? d : d + DEP_W'(1);
    endfunction

    function automatic logic [DEP_W-1:0] depth_sat_dec(input logic [DEP_W-1:0] d);
        return (d == '0) ? d : d - DEP_W'(1);
    endfunction

    // Size-casting the signed offset sign-extends it to the PC width, so the
    // add below wraps modulo 2^ADDR_W for both directions.
    assign off_sext  = ADDR_W'($signed(offset_i));
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign pc_br     = pc_q + $unsigned(off_sext);
    assign stack_top = stack_q[sp_q - SP_W'(1)];

    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        reti  = 1'b0;
        unique case (pcoper_i)
            4'b0000: pc_d = pc_inc;
            4'b0001: pc_d = ADDR_W'(RESET_VEC);
            4'b0100: pc_d = zero_i    ? pc_br : pc_inc;
            4'b0101: pc_d = !zero_i   ? pc_br : pc_inc;
            4'b0110: pc_d = carry_i   ? pc_br : pc_inc;
            4'b0111: pc_d = !carry_i  ? pc_br : pc_inc;
            4'b1000: pc_d = addr_i;
            4'b1001: begin
                pc_d = addr_i;
                push = 1'b1;
            end
            4'b1010: begin
                pc_d = stack_top;
                pop  = 1'b1;
            end
            4'b1100: begin
                pc_d = int_pc_q;
                reti = 1'b1;
            end
            default: pc_d = pc_q;
        endcase

`ifdef PC_SEQ_STACK_CHECK_EN
        // A refused push still takes the jump; a refused pop falls through.
        push_ok = push && (depth_q != DEP_W'(STACK_DEPTH));
        pop_ok  = pop  && (depth_q != '0);
        ovf_set = push && !push_ok;
        unf_set = pop  && !pop_ok;
        if (unf_set) begin
            pc_d = pc_inc;
        end
`else
        push_ok = push;
        pop_ok  = pop;
        ovf_set = 1'b0;
        unf_set = 1'b0;
`endif

        sp_d    = sp_q;
        depth_d = depth_q;
        if (push_ok) begin
            sp_d    = sp_q + SP_W'(1);
            depth_d = depth_sat_inc(depth_q);
        end else if (pop_ok) begin
            sp_d    = sp_q - SP_W'(1);
            depth_d = depth_sat_dec(depth_q);
        end
    end

`ifdef PC_SEQ_STACK_CHECK_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (en_i) begin
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
        end
    end

    assign stack_ovf_o = ovf_q;
    assign stack_unf_o = unf_q;
`else
    assign stack_ovf_o = 1'b0;
    assign stack_unf_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            pc_q     <= ADDR_W'(RESET_VEC);
            int_pc_q <= '0;
            sp_q     <= '0;
            depth_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (en_i) begin
                sp_q    <= sp_d;
                depth_q <= depth_d;
                if (push_ok) begin
                    stack_q[sp_q] <= pc_inc;
                end
                unique case (state_q)
                    ST_RUN: begin
                        // Taking an interrupt parks the PC the op would have
                        // produced; the op's stack effect still happens.
                        if (int_req_i) begin
                            int_pc_q <= pc_d;
                            pc_q     <= ADDR_W'(INT_VEC);
                            state_q  <= ST_INT;
                            ack_q    <= 1'b1;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                    ST_INT: begin
                        pc_q <= pc_d;
                        if (reti) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

    assign pc_o      = pc_q;
    assign int_ack_o = ack_q;
    assign int_act_o = (state_q == ST_INT);
    assign depth_o   = depth_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq -- self-checking bench for pc_seq with default parameters.
// A behavioural model tracks the expected outputs every cycle; directed
// steps additionally pin hand-computed literal values.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [3:0]  pcoper_i = 4'b0000;
    logic        carry_i = 1'b0;
    logic        zero_i = 1'b0;
    logic [7:0]  offset_i = 8'h00;
    logic [11:0] addr_i = 12'h000;
    logic        int_req_i = 1'b0;
    logic [11:0] pc_o;
    logic        int_ack_o;
    logic        int_act_o;
    logic [3:0]  depth_o;
    logic        stack_ovf_o;
    logic        stack_unf_o;

    int checks = 0;
    int failures = 0;

`ifdef PC_SEQ_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    pc_seq dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .pcoper_i    (pcoper_i),
        .carry_i     (carry_i),
        .zero_i      (zero_i),
        .offset_i    (offset_i),
        .addr_i      (addr_i),
        .int_req_i   (int_req_i),
        .pc_o        (pc_o),
        .int_ack_o   (int_ack_o),
        .int_act_o   (int_act_o),
        .depth_o     (depth_o),
        .stack_ovf_o (stack_ovf_o),
        .stack_unf_o (stack_unf_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit started = 1'b0;
    int m_pc, m_int_pc, m_depth, m_ptr, nxt, inc, sext;
    bit m_int, m_ack, m_ovf, m_unf, leave_int;
    int m_mem [8];

    initial begin
        for (int i = 0; i < 8; i++) m_mem[i] = 0;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_i) begin
            m_pc = 0; m_int = 0; m_int_pc = 0; m_depth = 0; m_ptr = 0;
            m_ack = 0; m_ovf = 0; m_unf = 0;
            started = 1'b1;
        end else if (started) begin
            m_ack = 0;
            if (en_i) begin
                inc  = (m_pc + 1) % 4096;
                sext = (offset_i >= 8'd128) ? int'(offset_i) - 256 : int'(offset_i);
                nxt  = m_pc;
                leave_int = 0;
                case (pcoper_i)
                    4'd0:  nxt = inc;
                    4'd1:  nxt = 0;
                    4'd4:  nxt = zero_i   ? ((m_pc + sext) & 'hFFF) : inc;
                    4'd5:  nxt = !zero_i  ? ((m_pc + sext) & 'hFFF) : inc;
                    4'd6:  nxt = carry_i  ? ((m_pc + sext) & 'hFFF) : inc;
                    4'd7:  nxt = !carry_i ? ((m_pc + sext) & 'hFFF) : inc;
                    4'd8:  nxt = int'(addr_i);
                    4'd9: begin
                        nxt = int'(addr_i);
                        if (CHK && m_depth == 8) m_ovf = 1;
                        else begin
                            m_mem[m_ptr % 8] = inc;
                            m_ptr++;
                            if (m_depth < 8) m_depth++;
                        end
                    end
                    4'd10: begin
                        if (CHK && m_depth == 0) begin
                            m_unf = 1;
                            nxt = inc;
                        end else begin
                            m_ptr--;
                            nxt = m_mem[((m_ptr % 8) + 8) % 8];
                            if (m_depth > 0) m_depth--;
                        end
                    end
                    4'd12: begin
                        nxt = m_int_pc;
                        leave_int = 1;
                    end
                    default: nxt = m_pc;
                endcase
                if (!m_int && int_req_i) begin
                    m_int_pc = nxt; m_pc = 1; m_int = 1; m_ack = 1;
                end else begin
                    m_pc = nxt;
                    if (leave_int) m_int = 0;
                end
            end
        end
        #1;
        if (started) begin
            cmp("model_pc",    32'(pc_o),        32'(m_pc));
            cmp("model_ack",   32'(int_ack_o),   32'(m_ack));
            cmp("model_act",   32'(int_act_o),   32'(m_int));
            cmp("model_depth", 32'(depth_o),     32'(m_depth));
            cmp("model_ovf",   32'(stack_ovf_o), 32'(m_ovf));
            cmp("model_unf",   32'(stack_unf_o), 32'(m_unf));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [3:0] op, input logic [11:0] a, input logic [7:0] off,
                        input logic z, input logic c, input logic irq,
                        input logic e, input logic r);
        @(negedge clk);
        pcoper_i = op; addr_i = a; offset_i = off; zero_i = z; carry_i = c;
        int_req_i = irq; en_i = e; rst_i = r;
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [3:0] op, input logic [11:0] a, input logic [7:0] off,
                      input logic z, input logic c, input logic irq);
        step(op, a, off, z, c, irq, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        step(4'd0, 12'h000, 8'h00, 0, 0, 0, 1, 1);
        cmp("rst_pc", 32'(pc_o), 32'h000);
        cmp("rst_depth", 32'(depth_o), 0);
        cmp("rst_ack", 32'(int_ack_o), 0);
        cmp("rst_act", 32'(int_act_o), 0);
        cmp("rst_ovf", 32'(stack_ovf_o), 0);
        cmp("rst_unf", 32'(stack_unf_o), 0);

        // Increment sequence 0 -> 1,2,3
        for (int i = 1; i <= 3; i++) begin
            go(4'd0, 12'h000, 8'h00, 0, 0, 0);
            cmp("inc_pc", 32'(pc_o), 32'(i));
        end

        // Conditional branches
        go(4'd8, 12'h010, 8'h00, 0, 0, 0);
        go(4'd4, 12'h000, 8'hFE, 1, 0, 0);
        cmp("bz_taken", 32'(pc_o), 32'h00E);
        go(4'd8, 12'h010, 8'h00, 0, 0, 0);
        go(4'd4, 12'h000, 8'hFE, 0, 0, 0);
        cmp("bz_not_taken", 32'(pc_o), 32'h011);
        go(4'd5, 12'h000, 8'h05, 0, 0, 0);
        cmp("bnz_taken", 32'(pc_o), 32'h016);
        go(4'd6, 12'h000, 8'h80, 0, 1, 0);
        cmp("bc_neg_wrap", 32'(pc_o), 32'hF96);
        go(4'd7, 12'h000, 8'h10, 0, 1, 0);
        cmp("bnc_not_taken", 32'(pc_o), 32'hF97);
        go(4'd8, 12'hFFF, 8'h00, 0, 0, 0);
        go(4'd0, 12'h000, 8'h00, 0, 0, 0);
        cmp("inc_wrap", 32'(pc_o), 32'h000);

        // Undefined op holds; op 0001 loads the reset vector
        go(4'd8, 12'h234, 8'h00, 0, 0, 0);
        go(4'd2, 12'h555, 8'h00, 0, 0, 0);
        cmp("undef_hold", 32'(pc_o), 32'h234);
        go(4'd1, 12'h555, 8'h00, 0, 0, 0);
        cmp("reset_vec_op", 32'(pc_o), 32'h000);

        // Call / return
        go(4'd8, 12'h020, 8'h00, 0, 0, 0);
        go(4'd9, 12'h100, 8'h00, 0, 0, 0);
        cmp("call1_pc", 32'(pc_o), 32'h100);
        cmp("call1_depth", 32'(depth_o), 1);
        go(4'd9, 12'h200, 8'h00, 0, 0, 0);
        cmp("call2_pc", 32'(pc_o), 32'h200);
        cmp("call2_depth", 32'(depth_o), 2);
        go(4'd10, 12'h000, 8'h00, 0, 0, 0);
        cmp("ret1_pc", 32'(pc_o), 32'h101);
        cmp("ret1_depth", 32'(depth_o), 1);
        go(4'd10, 12'h000, 8'h00, 0, 0, 0);
        cmp("ret2_pc", 32'(pc_o), 32'h021);
        cmp("ret2_depth", 32'(depth_o), 0);

        // Interrupt entry, ignored second request, reti
        go(4'd8, 12'h050, 8'h00, 0, 0, 0);
        go(4'd8, 12'h300, 8'h00, 0, 0, 1);
        cmp("int_pc", 32'(pc_o), 32'h001);
        cmp("int_ack", 32'(int_ack_o), 1);
        cmp("int_act", 32'(int_act_o), 1);
        go(4'd0, 12'h000, 8'h00, 0, 0, 1);
        cmp("int2_pc", 32'(pc_o), 32'h002);
        cmp("int2_ack", 32'(int_ack_o), 0);
        go(4'd12, 12'h000, 8'h00, 0, 0, 0);
        cmp("reti_pc", 32'(pc_o), 32'h300);
        cmp("reti_act", 32'(int_act_o), 0);
        go(4'd0, 12'h000, 8'h00, 0, 0, 0);
        go(4'd12, 12'h000, 8'h00, 0, 0, 0);
        cmp("reti_run_pc", 32'(pc_o), 32'h300);
        cmp("reti_run_act", 32'(int_act_o), 0);

        // Request with en_i low is not taken and the PC holds
        step(4'd0, 12'h000, 8'h00, 0, 0, 1, 0, 0);
        cmp("en0_pc", 32'(pc_o), 32'h300);
        cmp("en0_ack", 32'(int_ack_o), 0);
        cmp("en0_act", 32'(int_act_o), 0);

        // Nine calls then nine returns
        step(4'd0, 12'h000, 8'h00, 0, 0, 0, 1, 1);
        go(4'd8, 12'h400, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            go(4'd9, 12'(12'h400 + 16 * i), 8'h00, 0, 0, 0);
        end
        cmp("ovf_pc", 32'(pc_o), 32'h490);
        cmp("ovf_depth", 32'(depth_o), 8);
        cmp("ovf_flag", 32'(stack_ovf_o), 32'(CHK));
        cmp("ovf_unf", 32'(stack_unf_o), 0);
        for (int i = 1; i <= 9; i++) begin
            go(4'd10, 12'h000, 8'h00, 0, 0, 0);
        end
        cmp("unf_pc", 32'(pc_o), CHK ? 32'h402 : 32'h481);
        cmp("unf_depth", 32'(depth_o), 0);
        cmp("unf_flag", 32'(stack_unf_o), 32'(CHK));

        // Reset beats a concurrent call and interrupt
        go(4'd9, 12'h123, 8'h00, 0, 0, 0);
        cmp("pre_rst_depth", 32'(depth_o), 1);
        step(4'd9, 12'h555, 8'h00, 0, 0, 1, 1, 1);
        cmp("rst_call_pc", 32'(pc_o), 32'h000);
        cmp("rst_call_depth", 32'(depth_o), 0);
        cmp("rst_call_ack", 32'(int_ack_o), 0);
        cmp("rst_call_act", 32'(int_act_o), 0);
        cmp("rst_call_ovf", 32'(stack_ovf_o), 0);
        go(4'd0, 12'h000, 8'h00, 0, 0, 0);
        cmp("post_rst_pc", 32'(pc_o), 32'h001);

        step(4'd0, 12'h000, 8'h00, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
